// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO read-side controller.
// Buffer state encoding, stats counter width and an occupancy helper.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam int DRAINED_CNT_W = 16;

    function automatic logic [1:0] buf_entries(buf_state_e s);
        logic [1:0] n;
        n = 2'd0;
        unique case (s)
            BUF_ONE: n = 2'd1;
            BUF_TWO: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream of fifo_reader.
// master = the reader itself, slave = FIFO and consumer side.
interface fifo_reader_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_empty;
    logic             fifo_read;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        input  fifo_data_out,
        input  fifo_empty,
        input  m_ready,
        output fifo_read,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_data_out,
        output fifo_empty,
        output m_ready,
        input  fifo_read,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer absorbing the FIFO's registered read latency.
// head_q is always the oldest word; tail_q only holds data in BUF_TWO.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output buf_state_e       state_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push_i) begin
                    head_d  = data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push_i && pop_i) begin
                    head_d = data_i;
                end else if (push_i) begin
                    tail_d  = data_i;
                    state_d = BUF_TWO;
                end else if (pop_i) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = data_i;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // The read-issue rule must never let a word land in a full buffer
        assert (!(rstn && state_q == BUF_TWO && push_i && !pop_i));
        if (!rstn) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign state_o = state_q;
    assign valid_o = (state_q != BUF_EMPTY);
    assign head_o  = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: drains the FIFO into a valid/ready stream.
// Optional transfer counter enabled by FIFO_READER_STATS_EN.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int fifo_depth = 8,
    parameter int fifo_width = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    fifo_reader_if.master            bus,
    output logic [DRAINED_CNT_W-1:0] drained_cnt
);

    if (fifo_width < 1 || fifo_depth < 1 ||
        $clog2(fifo_depth + 1) > DRAINED_CNT_W) begin : g_bad_cfg
        $error("fifo_reader: unsupported fifo_depth/fifo_width");
    end

    buf_state_e      state;
    logic [1:0]      occ;
    logic            inflight_q, inflight_d;
    logic            pop;
    logic            rd;
    logic            valid;
    logic [fifo_width-1:0] head;

    assign pop = valid && bus.m_ready;
    assign occ = buf_entries(state) + {1'b0, inflight_q};

    // A read is allowed only if its word is sure to find a free slot
    assign rd = rstn && !bus.fifo_empty &&
                ((occ < 2'd2) || (occ == 2'd2 && pop));

    assign inflight_d = rd;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_reader_skid #(
        .WIDTH (fifo_width)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (inflight_q),
        .data_i  (bus.fifo_data_out),
        .pop_i   (pop),
        .state_o (state),
        .valid_o (valid),
        .head_o  (head)
    );

    assign bus.fifo_read = rd;
    assign bus.m_valid   = valid;
    assign bus.m_data    = head;

`ifdef FIFO_READER_STATS_EN
    logic [DRAINED_CNT_W-1:0] drained_q, drained_d;

    always_comb begin
        drained_d = drained_q;
        if (pop && drained_q != {DRAINED_CNT_W{1'b1}}) begin
            drained_d = drained_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drained_q <= '0;
        end else begin
            drained_q <= drained_d;
        end
    end

    assign drained_cnt = drained_q;
`else
    assign drained_cnt = '0;
`endif

endmodule
